// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line instruction cache answering datapath fetches.
// Misses are refilled from the memory controller one word at a time.
module icache_responder #(
    parameter int unsigned SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        iflush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int unsigned IDXW = $clog2(SETS);
    localparam int unsigned TAGW = 32 - 2 - IDXW;

    typedef enum logic {StIdle, StFill} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [SETS-1:0]   r_valid;
    logic [TAGW-1:0]   r_tag  [SETS];
    logic [31:0]       r_data [SETS];
    logic [29:0]       r_miss_word;
    logic [31:0]       r_hit_cnt;
    logic [31:0]       r_miss_cnt;

    logic [IDXW-1:0]   w_idx;
    logic [TAGW-1:0]   w_tag;
    logic [IDXW-1:0]   w_fill_idx;
    logic              w_lhit;
    logic              w_miss_start;
    logic              w_fill_done;
    logic              w_unused_lsbs;

    // Byte-offset bits never select anything in a word-per-line cache.
    assign w_unused_lsbs = ^imemaddr[1:0];

    assign w_idx      = imemaddr[IDXW+1:2];
    assign w_tag      = imemaddr[31:IDXW+2];
    assign w_fill_idx = r_miss_word[IDXW-1:0];
    assign w_lhit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    always_comb begin
        w_state_next = r_state;
        w_miss_start = 1'b0;
        w_fill_done  = 1'b0;
        ihit         = 1'b0;
        iREN         = 1'b0;
        iaddr        = 32'd0;
        unique case (r_state)
            StIdle: begin
                ihit = imemREN && w_lhit;
                if (imemREN && !w_lhit && !iflush) begin
                    w_miss_start = 1'b1;
                    w_state_next = StFill;
                end
            end
            StFill: begin
                iREN  = 1'b1;
                iaddr = {r_miss_word, 2'b00};
                if (!iwait) begin
                    w_fill_done  = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign imemload = r_data[w_idx];
    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= StIdle;
            r_valid     <= '0;
            r_miss_word <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            if (ihit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_miss_start) begin
                r_miss_word <= imemaddr[31:2];
                r_miss_cnt  <= r_miss_cnt + 32'd1;
            end
            // A flush landing on the completing fill leaves the line invalid.
            if (iflush) begin
                r_valid <= '0;
            end else if (w_fill_done) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data carry no reset; validity alone guards them.
    always_ff @(posedge CLK) begin
        if (!RST && w_fill_done) begin
            r_tag[w_fill_idx]  <= r_miss_word[29:IDXW];
            r_data[w_fill_idx] <= iload;
        end
    end
endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed cycle table plus a
// randomized run against a line-level reference model.
module tb_icache_responder;
    localparam int unsigned SETS = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iflush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int checks = 0;
    int errors = 0;

    icache_responder #(.SETS(SETS)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iflush   (iflush),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          rst;
        bit          req;
        logic [31:0] addr;
        bit          flush;
        bit          wt;
        logic [31:0] load;
        bit          e_hit;
        bit          e_ren;
        logic [31:0] e_iaddr;
        logic [31:0] e_load;
        logic [31:0] e_hc;
        logic [31:0] e_mc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit req, logic [31:0] addr, bit flush, bit wt,
                                logic [31:0] load, bit e_hit, bit e_ren,
                                logic [31:0] e_iaddr, logic [31:0] e_load,
                                logic [31:0] e_hc, logic [31:0] e_mc);
        vec_t v;
        v.rst = rst; v.req = req; v.addr = addr; v.flush = flush; v.wt = wt; v.load = load;
        v.e_hit = e_hit; v.e_ren = e_ren; v.e_iaddr = e_iaddr; v.e_load = e_load;
        v.e_hc = e_hc; v.e_mc = e_mc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model state: one record per line, plus the pending miss.
    bit          m_valid [SETS];
    logic [31:0] m_tag   [SETS];
    logic [31:0] m_data  [SETS];
    bit          m_fill;
    logic [31:0] m_addr;
    logic [31:0] m_hc;
    logic [31:0] m_mc;

    task automatic model_reset();
        for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
        m_fill = 1'b0;
        m_addr = 32'd0;
        m_hc   = 32'd0;
        m_mc   = 32'd0;
    endtask

    initial begin
        RST = 1'b1; imemREN = 1'b0; imemaddr = 32'd0; iflush = 1'b0;
        iwait = 1'b1; iload = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("reset_ihit", {31'd0, ihit}, 32'd0);
        chk("reset_iren", {31'd0, iREN}, 32'd0);
        chk("reset_iaddr", iaddr, 32'd0);
        chk("reset_hit_cnt", hit_cnt, 32'd0);
        chk("reset_miss_cnt", miss_cnt, 32'd0);

        //                rst req addr        fl wt load          hit ren iaddr      eload        hc  mc
        // cold miss on 0x40, memory busy three cycles
        vecs.push_back(mk(0, 1, 32'h40,  0, 1, 32'h0,        0, 0, 32'h0,   32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 32'h40,  0, 1, 32'h0,        0, 1, 32'h40,  32'h0,        0, 1));
        vecs.push_back(mk(0, 1, 32'h40,  0, 1, 32'h0,        0, 1, 32'h40,  32'h0,        0, 1));
        vecs.push_back(mk(0, 1, 32'h40,  0, 1, 32'h0,        0, 1, 32'h40,  32'h0,        0, 1));
        vecs.push_back(mk(0, 1, 32'h40,  0, 0, 32'h8C220004, 0, 1, 32'h40,  32'h0,        0, 1));
        vecs.push_back(mk(0, 1, 32'h40,  0, 1, 32'h0,        1, 0, 32'h0,   32'h8C220004, 0, 1));
        // low address bits ignored
        vecs.push_back(mk(0, 1, 32'h42,  0, 1, 32'h0,        1, 0, 32'h0,   32'h8C220004, 1, 1));
        vecs.push_back(mk(0, 1, 32'h42,  0, 1, 32'h0,        1, 0, 32'h0,   32'h8C220004, 2, 1));
        // conflict eviction on index 0
        vecs.push_back(mk(0, 1, 32'h00,  0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        3, 1));
        vecs.push_back(mk(0, 1, 32'h00,  0, 0, 32'h11111111, 0, 1, 32'h0,   32'h0,        3, 2));
        vecs.push_back(mk(0, 1, 32'h00,  0, 1, 32'h0,        1, 0, 32'h0,   32'h11111111, 3, 2));
        vecs.push_back(mk(0, 1, 32'h40,  0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        4, 2));
        vecs.push_back(mk(0, 1, 32'h40,  0, 0, 32'h8C220004, 0, 1, 32'h40,  32'h0,        4, 3));
        vecs.push_back(mk(0, 1, 32'h40,  0, 1, 32'h0,        1, 0, 32'h0,   32'h8C220004, 4, 3));
        vecs.push_back(mk(0, 1, 32'h00,  0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        5, 3));
        vecs.push_back(mk(0, 1, 32'h00,  0, 0, 32'h11111111, 0, 1, 32'h0,   32'h0,        5, 4));
        // redirect to 0x200 while 0x100 is filling
        vecs.push_back(mk(0, 1, 32'h100, 0, 1, 32'h0,        0, 0, 32'h0,   32'h0,        5, 4));
        vecs.push_back(mk(0, 1, 32'h200, 0, 1, 32'h0,        0, 1, 32'h100, 32'h0,        5, 5));
        vecs.push_back(mk(0, 1, 32'h200, 0, 0, 32'hAAAAAAAA, 0, 1, 32'h100, 32'h0,        5, 5));
        vecs.push_back(mk(0, 1, 32'h100, 0, 1, 32'h0,        1, 0, 32'h0,   32'hAAAAAAAA, 5, 5));
        vecs.push_back(mk(0, 1, 32'h200, 0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        6, 5));
        vecs.push_back(mk(0, 1, 32'h200, 0, 0, 32'h22222222, 0, 1, 32'h200, 32'h0,        6, 6));
        vecs.push_back(mk(0, 1, 32'h200, 0, 1, 32'h0,        1, 0, 32'h0,   32'h22222222, 6, 6));
        // flush coincident with fill completion
        vecs.push_back(mk(0, 1, 32'h44,  0, 1, 32'h0,        0, 0, 32'h0,   32'h0,        7, 6));
        vecs.push_back(mk(0, 1, 32'h44,  1, 0, 32'h33333333, 0, 1, 32'h44,  32'h0,        7, 7));
        vecs.push_back(mk(0, 1, 32'h44,  0, 1, 32'h0,        0, 0, 32'h0,   32'h0,        7, 7));
        vecs.push_back(mk(0, 1, 32'h44,  0, 0, 32'h33333333, 0, 1, 32'h44,  32'h0,        7, 8));
        vecs.push_back(mk(0, 1, 32'h44,  0, 1, 32'h0,        1, 0, 32'h0,   32'h33333333, 7, 8));
        // flush in idle: same-cycle hit still reported, then miss entry blocked
        vecs.push_back(mk(0, 1, 32'h44,  1, 1, 32'h0,        1, 0, 32'h0,   32'h33333333, 8, 8));
        vecs.push_back(mk(0, 1, 32'h200, 1, 1, 32'h0,        0, 0, 32'h0,   32'h0,        9, 8));
        vecs.push_back(mk(0, 1, 32'h200, 0, 1, 32'h0,        0, 0, 32'h0,   32'h0,        9, 8));
        vecs.push_back(mk(0, 1, 32'h200, 0, 1, 32'h0,        0, 1, 32'h200, 32'h0,        9, 9));
        // reset while memory completes: nothing written
        vecs.push_back(mk(1, 1, 32'h200, 0, 0, 32'h44444444, 0, 1, 32'h200, 32'h0,        9, 9));
        vecs.push_back(mk(0, 1, 32'h200, 0, 1, 32'h0,        0, 0, 32'h0,   32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 32'h200, 0, 1, 32'h0,        0, 1, 32'h200, 32'h0,        0, 1));
        vecs.push_back(mk(1, 0, 32'h0,   0, 1, 32'h0,        0, 1, 32'h200, 32'h0,        0, 1));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1, 32'h0,        0, 0, 32'h0,   32'h0,        0, 0));

        foreach (vecs[i]) begin
            @(posedge CLK);
            #1;
            RST = vecs[i].rst; imemREN = vecs[i].req; imemaddr = vecs[i].addr;
            iflush = vecs[i].flush; iwait = vecs[i].wt; iload = vecs[i].load;
            @(negedge CLK);
            chk($sformatf("vec%0d_ihit", i), {31'd0, ihit}, {31'd0, vecs[i].e_hit});
            chk($sformatf("vec%0d_iren", i), {31'd0, iREN}, {31'd0, vecs[i].e_ren});
            chk($sformatf("vec%0d_iaddr", i), iaddr, vecs[i].e_iaddr);
            chk($sformatf("vec%0d_hit_cnt", i), hit_cnt, vecs[i].e_hc);
            chk($sformatf("vec%0d_miss_cnt", i), miss_cnt, vecs[i].e_mc);
            if (vecs[i].e_hit) chk($sformatf("vec%0d_imemload", i), imemload, vecs[i].e_load);
        end

        // Randomized run: start from reset so model and DUT agree.
        @(posedge CLK);
        #1;
        RST = 1'b1; imemREN = 1'b0; iflush = 1'b0; iwait = 1'b1;
        @(posedge CLK);
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit          r_rst, r_req, r_fl, r_wt, e_lhit, e_hit;
            logic [31:0] r_addr, r_load;
            int          idx;
            logic [31:0] tag;
            #1;
            r_rst  = ($urandom_range(0, 299) == 0);
            r_req  = ($urandom_range(0, 9) < 8);
            r_addr = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
            r_fl   = ($urandom_range(0, 39) == 0);
            r_wt   = $urandom_range(0, 1) == 1;
            r_load = $urandom;
            RST = r_rst; imemREN = r_req; imemaddr = r_addr; iflush = r_fl;
            iwait = r_wt; iload = r_load;
            @(negedge CLK);
            idx    = int'((r_addr / 4) % SETS);
            tag    = r_addr / (4 * SETS);
            e_lhit = m_valid[idx] && (m_tag[idx] == tag);
            e_hit  = r_req && e_lhit && !m_fill;
            chk("rand_ihit", {31'd0, ihit}, {31'd0, e_hit});
            chk("rand_iren", {31'd0, iREN}, {31'd0, m_fill});
            chk("rand_iaddr", iaddr, m_fill ? m_addr : 32'd0);
            chk("rand_hit_cnt", hit_cnt, m_hc);
            chk("rand_miss_cnt", miss_cnt, m_mc);
            if (e_hit) chk("rand_imemload", imemload, m_data[idx]);
            if (r_rst) begin
                model_reset();
            end else begin
                if (e_hit) m_hc++;
                if (m_fill) begin
                    if (!r_wt) begin
                        m_fill = 1'b0;
                        m_valid[int'((m_addr / 4) % SETS)] = 1'b1;
                        m_tag[int'((m_addr / 4) % SETS)]   = m_addr / (4 * SETS);
                        m_data[int'((m_addr / 4) % SETS)]  = r_load;
                    end
                end else if (r_req && !e_lhit && !r_fl) begin
                    m_fill = 1'b1;
                    m_addr = r_addr & ~32'd3;
                    m_mc++;
                end
                if (r_fl) for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
            end
            @(posedge CLK);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Direct-mapped, one-word-per-line instruction cache on the cache side of the datapath instruction-fetch interface.
- It answers the datapath's imemREN/imemaddr requests with ihit/imemload.
- On a miss it acts as initiator toward the memory controller (iREN/iaddr, answered by iwait/iload).
- It is the responder the fetch stage's PC register stalls on.

Parameters:
- SETS, 16, number of lines; power of two, ≥2. IDXW = log2(SETS).
- TAGW, 32-2-IDXW, tag width derived from SETS (26 at default).

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  datapath fetch byte address; bits [1:0] ignored
- ihit  out  1  requested word valid this cycle
- imemload  out  32  instruction word; meaningful only when ihit=1
- iflush  in  1  invalidate all lines
- iREN  out  1  memory read request
- iaddr  out  32  memory read address, word aligned
- iwait  in  1  memory busy; iload valid in a cycle where iREN=1 and iwait=0
- iload  in  32  memory read data
- hit_cnt  out  32  count of cycles with ihit=1
- miss_cnt  out  32  count of IDLE->FILL transitions

Behaviour:
- Address split: idx = imemaddr[IDXW+1:2], tag = imemaddr[31:IDXW+2].
- Storage per line: valid bit, tag, 32-bit data.
- Lookup (combinational): lhit = valid[idx] & (tag_arr[idx]==tag).
- ihit = imemREN & lhit & (state==IDLE).
- imemload = data[idx] whenever ihit=1. It is don't-care otherwise; the bench must not check it.
- FSM states: IDLE, FILL.
- IDLE:
  - If imemREN & ~lhit & ~iflush: latch miss_addr = {imemaddr[31:2],2'b00}, go to FILL, increment miss_cnt.
  - Otherwise stay in IDLE.
- FILL:
  - iREN=1, iaddr=miss_addr.
  - On iwait=0: write data/tag and set valid at miss_addr's index, then go to IDLE.
  - The refill write lands at the edge. The matching fetch sees ihit=1 in the following cycle, provided imemaddr is unchanged.
- Outside FILL: iREN=0 and iaddr=0.
- Miss penalty: miss detected in cycle N; FILL from N+1; memory completes in cycle M (iwait=0); ihit in M+1. Minimum 2 cycles when iwait=0 immediately.
- imemaddr may change during FILL (branch redirect). The fill is still completed and written; it is not aborted. The new address is looked up once back in IDLE.
- imemREN dropping during FILL: the fill still completes.
- iflush:
  - Clears all valid bits at the edge.
  - If it coincides with fill completion, flush wins: the line stays invalid and the FSM still returns to IDLE.
  - iflush in IDLE blocks miss entry that cycle.
  - A hit in the same cycle as iflush still reports ihit=1, since lookup uses pre-edge state.
- Counters:
  - hit_cnt increments each cycle ihit=1; wraps at 2^32.
  - miss_cnt increments on each IDLE->FILL; wraps at 2^32.
  - Neither counter is cleared by iflush.
- Reset (RST=1 at edge):
  - state=IDLE; all valid=0; hit_cnt=0; miss_cnt=0; miss_addr=0.
  - Tag and data arrays need not reset.
  - Outputs after reset: ihit=0, iREN=0, iaddr=0.
  - Reset during FILL abandons the fill; nothing is written.
  - Memory must tolerate iREN dropping without completion.
- Lines are only ever written by a completed fill. There is no write path from the datapath.

Test Plan:
- Cold miss:
  - Stimulus: reset; imemREN=1, imemaddr=0x00000040, iwait=1 for 3 cycles then 0, iload=0x8C220004.
  - Response: iREN=1 and iaddr=0x40 for 4 cycles; ihit=1 with imemload=0x8C220004 in the next cycle; miss_cnt=1.
- Hit after fill: re-request 0x00000042 (low bits ignored) -> same-cycle ihit=1, imemload=0x8C220004, iREN=0; hit_cnt increments each such cycle.
- Conflict eviction (SETS=16):
  - Stimulus: fill 0x00000000 with 0x11111111, then request 0x00000040 (same index 0, different tag).
  - Response: miss; after the fill, 0x00 misses again; miss_cnt=3.
- Redirect during fill:
  - Stimulus: miss on 0x100; during FILL switch imemaddr to 0x200; complete with iload=0xAAAAAAAA.
  - Response: line for 0x100 holds 0xAAAAAAAA; 0x200 then misses; 0x100 later hits.
- Flush races:
  - iflush coincident with fill completion -> that address misses again afterwards.
  - iflush in IDLE -> all previously cached addresses miss; counters unchanged by the flush.
- Reset mid-fill: assert RST while in FILL -> iREN=0 next cycle, counters=0, and the prior address misses on re-request.
